// File: rtl/sha256_target_check.sv
// Tags in-order SHA-256 digests with nonces, compares each against the job target and
// queues hits in a FWFT FIFO. Define SHA_CHECK_STOP_ON_HIT_EN to halt after the first hit.
module sha256_target_check #(
  parameter int FIFO_DEPTH = 4,
  parameter int NONCE_W    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               job_load,
  input  logic [NONCE_W-1:0] job_nonce_base,
  input  logic [255:0]       job_target,
  input  logic [255:0]       digest_in,
  input  logic               digest_valid,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               found_valid,
  input  logic               found_ready,
  output logic               running,
  output logic               overflow,
  output logic               nonce_wrap
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // state | meaning
  // IDLE  | no job loaded, digests ignored
  // RUN   | tagging and comparing digests
  // HALT  | stopped after first hit, waits for job_load (SHA_CHECK_STOP_ON_HIT_EN)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NONCE_W-1:0] next_nonce;
  logic [255:0]       target_reg;
  logic [255:0]       hash_swap;
  logic               s1_valid, s2_valid, s2_hit;
  logic [255:0]       s1_hash;
  logic [NONCE_W-1:0] s1_nonce, s2_nonce;

  logic [NONCE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [NONCE_W-1:0] last_nonce;

  logic push_req, pop, full, do_push, halt_now, accept;

  always_comb begin
    hash_swap = '0;
    for (int i = 0; i < 32; i++) begin
      hash_swap[255-8*i -: 8] = digest_in[8*i +: 8];
    end
  end

  // a reload discards whatever is still in flight, including the stage-2 entry
  assign push_req = s2_valid & s2_hit & ~job_load;
  assign found_valid = (count != '0);
  assign pop = found_valid & found_ready;
  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push_req & (~full | pop);

`ifdef SHA_CHECK_STOP_ON_HIT_EN
  assign halt_now = (state_q == RUN) & push_req;
`else
  assign halt_now = 1'b0;
`endif

  assign accept  = (state_q == RUN) & digest_valid & ~job_load & ~halt_now;
  assign running = (state_q == RUN);
  assign found_nonce = found_valid ? mem[rd_ptr] : last_nonce;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (job_load) state_d = RUN;
      RUN: begin
        if (job_load)      state_d = RUN;
        else if (halt_now) state_d = HALT;
      end
      HALT: if (job_load) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      next_nonce <= '0;
      target_reg <= '0;
      s1_valid   <= 1'b0;
      s1_hash    <= '0;
      s1_nonce   <= '0;
      s2_valid   <= 1'b0;
      s2_hit     <= 1'b0;
      s2_nonce   <= '0;
      overflow   <= 1'b0;
      nonce_wrap <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_nonce <= '0;
    end else begin
      state_q  <= state_d;
      s1_valid <= accept;
      s2_valid <= s1_valid & ~job_load & ~halt_now;
      s2_hit   <= (s1_hash <= target_reg);
      s2_nonce <= s1_nonce;
      if (accept) begin
        s1_hash  <= hash_swap;
        s1_nonce <= next_nonce;
      end

      if (job_load) begin
        next_nonce <= job_nonce_base;
        target_reg <= job_target;
        overflow   <= 1'b0;
        nonce_wrap <= 1'b0;
      end else begin
        if (accept) begin
          next_nonce <= next_nonce + 1'b1;
          if (&next_nonce) nonce_wrap <= 1'b1;
        end
        if (push_req & full & ~pop) overflow <= 1'b1;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        last_nonce <= mem[rd_ptr];
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= s2_nonce;
  end

endmodule

// File: tb/tb_sha256_target_check.sv
// Directed bench for sha256_target_check with a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_sha256_target_check;
  localparam int DEPTH = 4;
  localparam int NW    = 32;
`ifdef SHA_CHECK_STOP_ON_HIT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          job_load = 1'b0;
  logic [NW-1:0] job_nonce_base = '0;
  logic [255:0]  job_target = '0;
  logic [255:0]  digest_in = '0;
  logic          digest_valid = 1'b0;
  logic [NW-1:0] found_nonce;
  logic          found_valid;
  logic          found_ready = 1'b0;
  logic          running, overflow, nonce_wrap;

  always #5 CLK = ~CLK;

  sha256_target_check #(.FIFO_DEPTH(DEPTH), .NONCE_W(NW)) dut (
    .CLK(CLK), .RST(RST), .job_load(job_load), .job_nonce_base(job_nonce_base),
    .job_target(job_target), .digest_in(digest_in), .digest_valid(digest_valid),
    .found_nonce(found_nonce), .found_valid(found_valid), .found_ready(found_ready),
    .running(running), .overflow(overflow), .nonce_wrap(nonce_wrap)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [NW-1:0] got[$];
  logic [NW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bswap(input logic [255:0] d);
    logic [255:0] h;
    h = '0;
    for (int i = 0; i < 32; i++) h = {h[247:0], d[8*i +: 8]};
    return h;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // reference model: FIFO as a queue, in-flight hits as (nonce, due edge) pairs
  logic [NW-1:0] m_q[$];
  logic [NW-1:0] pn[$];
  int            pd[$];
  logic [NW-1:0] m_last, m_next, dn;
  logic [255:0]  m_target;
  bit            m_ovf, m_wrap, m_pop, m_due, m_halt;
  int            m_state, cyc;

  always @(posedge CLK) begin
    if (RST) begin
      m_q.delete(); pn.delete(); pd.delete();
      m_last = '0; m_next = '0; m_target = '0;
      m_ovf = 0; m_wrap = 0; m_state = 0; cyc = 0;
    end else begin
      cyc++;
      m_pop  = (m_q.size() > 0) && found_ready;
      m_due  = (pd.size() > 0) && (pd[0] == cyc) && !job_load;
      m_halt = m_due && STOP_EN && (m_state == 1);
      if (m_pop) m_last = m_q.pop_front();
      if (m_due) begin
        dn = pn.pop_front();
        void'(pd.pop_front());
        if (m_q.size() < DEPTH) m_q.push_back(dn);
        else m_ovf = 1;
      end
      if (m_halt) begin
        pn.delete(); pd.delete();
        m_state = 2;
      end
      if (job_load) begin
        m_next = job_nonce_base; m_target = job_target;
        m_ovf = 0; m_wrap = 0; m_state = 1;
        pn.delete(); pd.delete();
      end else if (m_state == 1 && digest_valid && !m_halt) begin
        if (bswap(digest_in) <= m_target) begin
          pn.push_back(m_next);
          pd.push_back(cyc + 2);
        end
        if (m_next == '1) m_wrap = 1;
        m_next = m_next + 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("found_valid", found_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("found_nonce", found_nonce, m_q[0]);
      else chk("found_nonce_hold", found_nonce, m_last);
      chk("overflow", overflow, m_ovf);
      chk("nonce_wrap", nonce_wrap, m_wrap);
      chk("running", running, m_state == 1);
      if (found_valid && found_ready) got.push_back(found_nonce);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [NW-1:0] base, input logic [255:0] tgt);
    job_load = 1'b1; job_nonce_base = base; job_target = tgt;
    tick();
    job_load = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      digest_valid = 1'b1; digest_in = rnd();
      tick();
    end
    digest_valid = 1'b0;
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk({name, "_nonce"}, got[i], exp_q[i]);
    end
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] tgt2;
    tick(); tick();
    chk("rst_found_valid", found_valid, 0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_running", running, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_nonce_wrap", nonce_wrap, 0);
    chk("model_bswap_lo", bswap(256'h01), {8'h01, 248'h0});
    chk("model_bswap_hi", bswap({8'hab, 248'h0}), 256'hab);
    RST = 1'b0;
    chk_en = 1'b1;

    // three digests, all hit, latency 3
    found_ready = 1'b1;
    load(32'h100, '1);
    got.delete();
    digest_valid = 1'b1; digest_in = rnd(); tick();
    digest_in = rnd(); tick();
    chk("t1_latency_early", found_valid, 0);
    digest_in = rnd(); tick();
    digest_valid = 1'b0;
    chk("t1_latency_valid", found_valid, 1);
    chk("t1_first_nonce", found_nonce, 32'h100);
    wait_n(5);
    exp_q = '{32'h100, 32'h101, 32'h102};
    check_got("t1");
    chk("t1_overflow", overflow, 0);

    // compare boundary: byte order of the digest matters
    tgt2 = {32'h0, {224{1'b1}}};
    load(32'h200, tgt2);
    got.delete();
    d = rnd(); d[7:0] = 8'h01;
    digest_valid = 1'b1; digest_in = d; tick();
    digest_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_no_hit", found_valid, 0);
    end
    d = rnd(); d[31:0] = 32'h0;
    digest_valid = 1'b1; digest_in = d; tick();
    digest_valid = 1'b0;
    wait_n(5);
    exp_q = '{32'h201};
    check_got("t2");

    // overflow with a stalled consumer
    found_ready = 1'b0;
    load(32'h300, '1);
    got.delete();
    send(5);
    wait_n(5);
    chk("t3_overflow", overflow, 1);
    chk("t3_held_valid", found_valid, 1);
    chk("t3_head", found_nonce, 32'h300);
    found_ready = 1'b1;
    wait_n(6);
    exp_q = '{32'h300, 32'h301, 32'h302, 32'h303};
    check_got("t3");
    chk("t3_drained", found_valid, 0);
    chk("t3_hold_last", found_nonce, 32'h303);
    load(32'h0, '1);
    chk("t3_ovf_cleared", overflow, 0);

    // nonce wrap
    load(32'hffff_fffe, '1);
    got.delete();
    send(3);
    wait_n(6);
    exp_q = '{32'hffff_fffe, 32'hffff_ffff, 32'h0};
    check_got("t4");
    chk("t4_wrap", nonce_wrap, 1);

    // reload discards in-flight and coincident digests
    load(32'h40, '1);
    got.delete();
    digest_valid = 1'b1; digest_in = rnd(); tick();
    job_load = 1'b1; job_nonce_base = 32'h50; digest_in = rnd(); tick();
    job_load = 1'b0; digest_in = rnd(); tick();
    digest_valid = 1'b0;
    wait_n(6);
    exp_q = '{32'h50};
    check_got("t5");
    chk("t5_wrap_cleared", nonce_wrap, 0);

    // consecutive hits: halt or continue depending on build
    found_ready = 1'b0;
    load(32'h10, '1);
    got.delete();
    send(4);
    wait_n(6);
    chk("t6_running", running, !STOP_EN);
    chk("t6_head", found_nonce, 32'h10);
    found_ready = 1'b1;
    wait_n(6);
    if (STOP_EN) exp_q = '{32'h10};
    else exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    check_got("t6");
    load(32'h20, '1);
    chk("t6_resumed", running, 1);
    got.delete();
    send(1);
    wait_n(5);
    exp_q = '{32'h20};
    check_got("t6_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
